xmm_muldiv_unit: RTL and testbench

Iterative signed q15.48 fixed-point multiply/divide unit for the XMM datapath. It takes two 64-bit operands straight from the XMM register file read ports. It produces one saturated 64-bit result plus a single-cycle write-back strobe that drives the register file write port (`should_write`/`write_addr`/`write_data`). Latency is fixed per operation: 64 cycles for multiply, 112 for divide, 1 for divide-by-zero. One operation is in flight at a time.

---
 rtl/xmm_fixed_pkg.sv | 26 ++
 rtl/xmm_muldiv_unit_if.sv | 28 ++
 rtl/xmm_fixed_saturate.sv | 29 ++
 rtl/xmm_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_xmm_muldiv_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/xmm_fixed_pkg.sv
// Shared q15.48 constants, op encoding and FSM states for the XMM fixed-point units.
package xmm_fixed_pkg;

    localparam int XMM_W    = 64;
    localparam int XMM_FRAC = 48;

    localparam logic [XMM_W-1:0] XMM_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [XMM_W-1:0] XMM_MIN = 64'h8000_0000_0000_0000;

    localparam logic XMM_OP_MUL = 1'b0;
    localparam logic XMM_OP_DIV = 1'b1;

    localparam int MUL_ITERS = 64;
    localparam int DIV_ITERS = 112;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } xmm_state_e;

    function automatic logic [XMM_W-1:0] xmm_abs(input logic [XMM_W-1:0] v);
        return v[XMM_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/xmm_muldiv_unit_if.sv
// Issue/write-back bundle between the XMM register file and the mul/div unit.
interface xmm_muldiv_unit_if;
    import xmm_fixed_pkg::*;

    logic             start;
    logic             op;
    logic [XMM_W-1:0] src_a;
    logic [XMM_W-1:0] src_b;
    logic [4:0]       dst_addr;
    logic             flush;
    logic             busy;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [XMM_W-1:0] wb_data;
    logic             ovf;
    logic             dz;

    modport master (
        output start, op, src_a, src_b, dst_addr, flush,
        input  busy, wb_en, wb_addr, wb_data, ovf, dz
    );

    modport slave (
        input  start, op, src_a, src_b, dst_addr, flush,
        output busy, wb_en, wb_addr, wb_data, ovf, dz
    );

endinterface

// File: rtl/xmm_fixed_saturate.sv
// Applies a sign to an unsigned magnitude and clamps to q15.48; purely combinational.
module xmm_fixed_saturate
    import xmm_fixed_pkg::*;
#(
    parameter int MAG_W = 128
) (
    input  logic [MAG_W-1:0] mag_i,
    input  logic             neg_i,
    output logic [XMM_W-1:0] data_o,
    output logic             ovf_o
);

    logic             hi_nz;
    logic [XMM_W-1:0] low;

    always_comb begin
        hi_nz = |mag_i[MAG_W-1:XMM_W];
        low   = mag_i[XMM_W-1:0];
        if (!neg_i) begin
            ovf_o  = hi_nz | low[XMM_W-1];
            data_o = ovf_o ? XMM_MAX : low;
        end else begin
            // 2^63 negates exactly to MIN, so only magnitudes beyond it clamp
            ovf_o  = hi_nz | (low[XMM_W-1] & (|low[XMM_W-2:0]));
            data_o = ovf_o ? XMM_MIN : (~low + 1'b1);
        end
    end

endmodule

// File: rtl/xmm_muldiv_unit.sv
// Iterative signed q15.48 multiply (64 cycles) / restoring divide (112 cycles, 1 for div-by-zero).
// Single operation in flight; start while busy is dropped, flush aborts without write-back.
module xmm_muldiv_unit
    import xmm_fixed_pkg::*;
#(
    parameter int FRAC_BITS = XMM_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    xmm_muldiv_unit_if.slave  bus
);

    localparam int PW = 2 * XMM_W;
    localparam int QW = XMM_W + FRAC_BITS;

    xmm_state_e       state_q;
    logic             op_q, sign_q, divz_q;
    logic [4:0]       addr_q;
    logic [6:0]       cnt_q;
    logic [XMM_W-1:0] a_mag_q, b_mag_q;
    logic [PW-1:0]    prod_q, prod_d;
    logic [XMM_W-1:0] rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;

    logic             busy_q, wb_en_q, ovf_q, dz_q;
    logic [4:0]       wb_addr_q;
    logic [XMM_W-1:0] wb_data_q;

    logic [XMM_W-1:0] a_abs, b_abs;
    logic             start_dz;
    logic [XMM_W:0]   mul_sum, div_trial;
    logic [6:0]       iters_last;
    logic [PW-1:0]    sat_mag;
    logic [XMM_W-1:0] sat_data;
    logic             sat_ovf;

    always_comb begin
        a_abs    = xmm_abs(bus.src_a);
        b_abs    = xmm_abs(bus.src_b);
        start_dz = (bus.op == XMM_OP_DIV) && (bus.src_b == '0);

        // Shift-add: multiplier sits in the low half and drains out LSB first
        mul_sum = {1'b0, prod_q[PW-1:XMM_W]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
        prod_d  = {mul_sum, prod_q[XMM_W-1:1]};

        // Remainder stays below the divisor, so the 64-bit subtract cannot wrap
        div_trial = {rem_q, quo_q[QW-1]};
        if (div_trial >= {1'b0, b_mag_q}) begin
            rem_d = div_trial[XMM_W-1:0] - b_mag_q;
            quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
            rem_d = div_trial[XMM_W-1:0];
            quo_d = {quo_q[QW-2:0], 1'b0};
        end

        iters_last = (op_q == XMM_OP_DIV) ? 7'(DIV_ITERS - 1) : 7'(MUL_ITERS - 1);
        sat_mag    = (op_q == XMM_OP_DIV) ? {{(PW-QW){1'b0}}, quo_d} : (prod_d >> FRAC_BITS);
    end

    xmm_fixed_saturate #(.MAG_W(PW)) u_sat (
        .mag_i  (sat_mag),
        .neg_i  (sign_q),
        .data_o (sat_data),
        .ovf_o  (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 1'b0;
            sign_q    <= 1'b0;
            divz_q    <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    wb_en_q <= 1'b0;
                    if (bus.start) begin
                        // Div-by-zero takes one RUN cycle without raising busy
                        state_q <= ST_RUN;
                        busy_q  <= !start_dz;
                        divz_q  <= start_dz;
                        op_q    <= bus.op;
                        addr_q  <= bus.dst_addr;
                        sign_q  <= bus.src_a[XMM_W-1] ^ bus.src_b[XMM_W-1];
                        a_mag_q <= a_abs;
                        b_mag_q <= b_abs;
                        cnt_q   <= '0;
                        prod_q  <= {{XMM_W{1'b0}}, b_abs};
                        rem_q   <= '0;
                        quo_q   <= {a_abs, {FRAC_BITS{1'b0}}};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                        if (op_q == XMM_OP_DIV) begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                        end else begin
                            prod_q <= prod_d;
                        end
                        if (divz_q || (cnt_q == iters_last)) begin
                            state_q   <= ST_DONE;
                            busy_q    <= 1'b0;
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= addr_q;
                            // With B = 0 the sign register holds sign(A)
                            wb_data_q <= divz_q ? (sign_q ? XMM_MIN : XMM_MAX) : sat_data;
                            ovf_q     <= divz_q ? 1'b0 : sat_ovf;
                            dz_q      <= divz_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;
    assign bus.ovf     = ovf_q;
    assign bus.dz      = dz_q;

endmodule

// File: tb/tb_xmm_muldiv_unit.sv
// Bench for xmm_muldiv_unit: directed vectors, abort cases and random ops against an arithmetic model.
module tb_xmm_muldiv_unit;
    import xmm_fixed_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    xmm_muldiv_unit_if bus ();

    xmm_muldiv_unit #(.FRAC_BITS(XMM_FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
        end
    endtask

    // Exact arithmetic on magnitudes, then truncate/saturate as a q15.48 value
    function automatic void ref_op(input logic op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] d, output logic ov, output logic z);
        logic [127:0] am, bm, m;
        logic         neg;
        am  = {64'd0, a[63] ? (64'd0 - a) : a};
        bm  = {64'd0, b[63] ? (64'd0 - b) : b};
        neg = a[63] ^ b[63];
        ov  = 1'b0;
        z   = 1'b0;
        if (op && b == 64'd0) begin
            z = 1'b1;
            d = a[63] ? XMM_MIN : XMM_MAX;
        end else begin
            m = op ? ((am << XMM_FRAC) / bm) : ((am * bm) >> XMM_FRAC);
            if (!neg && m > 128'h7FFF_FFFF_FFFF_FFFF) begin
                ov = 1'b1;
                d  = XMM_MAX;
            end else if (neg && m > 128'h8000_0000_0000_0000) begin
                ov = 1'b1;
                d  = XMM_MIN;
            end else begin
                d = neg ? (64'd0 - m[63:0]) : m[63:0];
            end
        end
    endfunction

    // Called at a falling edge; returns at the falling edge of the DONE cycle
    task automatic do_op(input logic op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] addr, input string tag, output logic [63:0] got);
        logic [63:0] ed;
        logic        eo, ez;
        int          lat, exp_lat;
        ref_op(op, a, b, ed, eo, ez);
        exp_lat = ez ? 1 : (op ? DIV_ITERS : MUL_ITERS);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.dst_addr = addr;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.op       = 1'($urandom_range(0, 1));
        bus.src_a    = {$urandom, $urandom};
        bus.src_b    = {$urandom, $urandom};
        bus.dst_addr = 5'($urandom_range(0, 31));
        chk({tag, ".busy_start"}, 64'(bus.busy), 64'(!ez));
        lat = 0;
        while (!bus.wb_en && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        got = bus.wb_data;
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".data"}, bus.wb_data, ed);
        chk({tag, ".ovf"}, 64'(bus.ovf), 64'(eo));
        chk({tag, ".dz"}, 64'(bus.dz), 64'(ez));
        chk({tag, ".addr"}, 64'(bus.wb_addr), 64'(addr));
        chk({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic watch_no_wb(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.wb_en) seen++;
        end
        chk({tag, ".no_wb"}, 64'(seen), 64'd0);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] w;
        logic [63:0] v;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       v = w;
            1:       v = {{24{w[39]}}, w[39:0]};
            2:       v = {{40{w[23]}}, w[23:0]};
            3:       v = {{12{w[51]}}, w[51:0]};
            default: v = ($urandom_range(0, 1) != 0) ? 64'd0 : XMM_MIN;
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] got;
        logic        rop;
        logic [63:0] ra, rb;

        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 1'b0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.dst_addr = '0;
        bus.flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.wb_en", 64'(bus.wb_en), 64'd0);
        chk("rst.wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("rst.wb_data", bus.wb_data, 64'd0);
        chk("rst.ovf", 64'(bus.ovf), 64'd0);
        chk("rst.dz", 64'(bus.dz), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_op(XMM_OP_MUL, 64'h0001_8000_0000_0000, 64'h0002_0000_0000_0000, 5'd3, "mul_1p5x2", got);
        chk("mul_1p5x2.const", got, 64'h0003_0000_0000_0000);
        @(negedge clk);
        chk("mul_1p5x2.one_pulse", 64'(bus.wb_en), 64'd0);

        do_op(XMM_OP_MUL, 64'hFFFE_8000_0000_0000, 64'h0002_0000_0000_0000, 5'd7, "mul_neg", got);
        chk("mul_neg.const", got, 64'hFFFD_0000_0000_0000);
        do_op(XMM_OP_MUL, 64'h0000_8000_0000_0000, 64'h0004_0000_0000_0000, 5'd9, "mul_b2b", got);
        chk("mul_b2b.const", got, 64'h0002_0000_0000_0000);
        @(negedge clk);

        do_op(XMM_OP_DIV, 64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000, 5'd12, "div_1by3", got);
        chk("div_1by3.const", got, 64'h0000_5555_5555_5555);
        @(negedge clk);
        do_op(XMM_OP_MUL, 64'h4000_0000_0000_0000, 64'h0004_0000_0000_0000, 5'd1, "mul_ovf_pos", got);
        chk("mul_ovf_pos.const", got, XMM_MAX);
        @(negedge clk);
        do_op(XMM_OP_MUL, 64'hC000_0000_0000_0000, 64'h0004_0000_0000_0000, 5'd2, "mul_ovf_neg", got);
        chk("mul_ovf_neg.const", got, XMM_MIN);
        @(negedge clk);
        do_op(XMM_OP_MUL, 64'hC000_0000_0000_0000, 64'h0002_0000_0000_0000, 5'd4, "mul_exact_min", got);
        chk("mul_exact_min.const", got, XMM_MIN);
        @(negedge clk);
        do_op(XMM_OP_DIV, 64'hFFFF_0000_0000_0000, 64'd0, 5'd30, "div_neg_by0", got);
        chk("div_neg_by0.const", got, XMM_MIN);
        @(negedge clk);
        do_op(XMM_OP_DIV, 64'd0, 64'd0, 5'd31, "div_0by0", got);
        chk("div_0by0.const", got, XMM_MAX);
        @(negedge clk);

        // Flush part-way through a divide
        bus.start = 1'b1; bus.op = XMM_OP_DIV;
        bus.src_a = 64'h0005_0000_0000_0000; bus.src_b = 64'h0002_0000_0000_0000; bus.dst_addr = 5'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush.busy", 64'(bus.busy), 64'd0);
        watch_no_wb("flush", 150);

        // Reset part-way through a divide
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst.busy", 64'(bus.busy), 64'd0);
        chk("mid_rst.wb_en", 64'(bus.wb_en), 64'd0);
        chk("mid_rst.wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("mid_rst.wb_data", bus.wb_data, 64'd0);
        chk("mid_rst.ovf", 64'(bus.ovf), 64'd0);
        chk("mid_rst.dz", 64'(bus.dz), 64'd0);
        reset = 1'b1;
        watch_no_wb("mid_rst", 150);
        do_op(XMM_OP_MUL, 64'hFFFF_4000_0000_0000, 64'h0003_0000_0000_0000, 5'd17, "mul_after_rst", got);
        chk("mul_after_rst.const", got, 64'hFFFD_C000_0000_0000);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            rop = 1'($urandom_range(0, 1));
            ra  = rnd_operand();
            rb  = ($urandom_range(0, 9) == 0) ? 64'd0 : rnd_operand();
            do_op(rop, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", i), got);
        end
        @(negedge clk);
        chk("final.one_pulse", 64'(bus.wb_en), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
